// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix-row server and its column gather helper.
package mat_pkg;

    localparam int unsigned MAT_SIZE  = 4;
    localparam int unsigned MAT_WIDTH = 64;
    localparam int unsigned CNT_W     = 16;

    typedef struct packed {
        logic [MAT_WIDTH-1:0] imag;
        logic [MAT_WIDTH-1:0] re;
    } complex_t;

    typedef complex_t [MAT_SIZE-1:0]     row_t;
    typedef logic [$clog2(MAT_SIZE)-1:0] addr_t;

    typedef logic [0:0] state_t;
    localparam state_t IDLE   = 1'b0;
    localparam state_t ENGINE = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mat_col_gather.sv
// Combinational column select: element k of the output is element col_i of row k.
module mat_col_gather
    import mat_pkg::*;
#(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic [SIZE*SIZE*2*WIDTH-1:0] mem_flat_i,
    input  logic [$clog2(SIZE)-1:0]      col_i,
    output logic [SIZE*2*WIDTH-1:0]      col_row_o
);
    localparam int unsigned EW = 2 * WIDTH;
    localparam int unsigned RW = SIZE * EW;

    always_comb begin
        col_row_o = '0;
        for (int k = 0; k < int'(SIZE); k++) begin
            col_row_o[k*EW +: EW] = mem_flat_i[k*RW + int'(col_i)*EW +: EW];
        end
    end

endmodule

// File: rtl/mat_row_server.sv
// Row memory serving lu/triang_matrix_inv engine reads and write-backs, with an idle-time host port.
// Define MAT_ROW_SERVER_TRANSPOSE_EN to enable host column (transposed) reads.
module mat_row_server
    import mat_pkg::*;
#(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      start_i,
    input  logic                      done_i,
    input  logic [$clog2(SIZE)-1:0]   rd_addr_i,
    input  logic                      rd_addr_valid_i,
    output logic [SIZE*2*WIDTH-1:0]   rd_row_o,
    output logic [$clog2(SIZE)-1:0]   rd_addr_o,
    output logic                      rd_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]   wr_row_i,
    input  logic [$clog2(SIZE)-1:0]   wr_addr_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic                      host_we_i,
    input  logic [$clog2(SIZE)-1:0]   host_addr_i,
    input  logic [SIZE*2*WIDTH-1:0]   host_row_i,
    input  logic                      host_re_i,
    input  logic                      host_rd_col_i,
    output logic [SIZE*2*WIDTH-1:0]   host_row_o,
    output logic                      host_rd_valid_o,
    output logic                      host_err_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          rd_cnt_o,
    output logic [CNT_W-1:0]          wr_cnt_o
);
    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned RW = SIZE * 2 * WIDTH;

    logic [RW-1:0]    mem_q   [SIZE];
    logic [RW-1:0]    mem_fwd [SIZE];
    state_t           state_q;
    logic [RW-1:0]    rd_row_q, host_row_q, host_data;
    logic [AW-1:0]    rd_addr_q;
    logic             rd_valid_q, host_rd_valid_q, host_err_q;
    logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;
    logic             busy, eng_rd, eng_wr, host_rd_ok, host_wr_ok;

    assign busy       = (state_q == ENGINE);
    assign eng_rd     = busy && rd_addr_valid_i && !flush_i;
    assign eng_wr     = busy && wr_valid_i;
    assign host_rd_ok = !busy && host_re_i && !flush_i;
    assign host_wr_ok = !busy && host_we_i;

    // Post-write view of the memory: both read ports take it, giving write-first forwarding.
    always_comb begin
        mem_fwd = mem_q;
        for (int k = 0; k < int'(SIZE); k++) begin
            if (eng_wr && wr_addr_i == AW'(k))       mem_fwd[k] = wr_row_i;
            if (host_wr_ok && host_addr_i == AW'(k)) mem_fwd[k] = host_row_i;
        end
    end

`ifdef MAT_ROW_SERVER_TRANSPOSE_EN
    logic [SIZE*RW-1:0] mem_flat;
    logic [RW-1:0]      col_row;

    for (genvar k = 0; k < int'(SIZE); k++) begin : g_flat
        assign mem_flat[k*RW +: RW] = mem_fwd[k];
    end

    mat_col_gather #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_col_gather (
        .mem_flat_i (mem_flat),
        .col_i      (host_addr_i),
        .col_row_o  (col_row)
    );

    assign host_data = host_rd_col_i ? col_row : mem_fwd[host_addr_i];
`else
    logic unused_rd_col;
    assign unused_rd_col = host_rd_col_i;
    assign host_data     = mem_fwd[host_addr_i];
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(SIZE); k++) mem_q[k] <= '0;
            state_q         <= IDLE;
            rd_row_q        <= '0;
            rd_addr_q       <= '0;
            rd_valid_q      <= 1'b0;
            host_row_q      <= '0;
            host_rd_valid_q <= 1'b0;
            host_err_q      <= 1'b0;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
        end else begin
            mem_q <= mem_fwd;

            if (flush_i)               state_q <= IDLE;
            else if (!busy && start_i) state_q <= ENGINE;
            else if (busy && done_i)   state_q <= IDLE;

            if (!flush_i && !busy && start_i) begin
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
            end else begin
                if (eng_rd) rd_cnt_q <= sat_inc(rd_cnt_q);
                if (eng_wr) wr_cnt_q <= sat_inc(wr_cnt_q);
            end

            rd_valid_q <= eng_rd;
            if (eng_rd) begin
                rd_row_q  <= mem_fwd[rd_addr_i];
                rd_addr_q <= rd_addr_i;
            end

            host_rd_valid_q <= host_rd_ok;
            if (host_rd_ok) host_row_q <= host_data;
            host_err_q <= busy && (host_we_i || host_re_i);
        end
    end

    assign rd_row_o        = rd_row_q;
    assign rd_addr_o       = rd_addr_q;
    assign rd_valid_o      = rd_valid_q;
    assign wr_ready_o      = busy;
    assign host_row_o      = host_row_q;
    assign host_rd_valid_o = host_rd_valid_q;
    assign host_err_o      = host_err_q;
    assign busy_o          = busy;
    assign rd_cnt_o        = rd_cnt_q;
    assign wr_cnt_o        = wr_cnt_q;

endmodule

// File: tb/tb_mat_row_server.sv
// Scoreboard bench for mat_row_server; inputs change on negedge, outputs sampled on the next negedge.
module tb_mat_row_server;
    localparam int SIZE = 4;
    localparam int WIDTH = 64;
    localparam int AW = 2;
    localparam int EW = 2 * WIDTH;
    localparam int RW = SIZE * EW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, start, done;
    logic [AW-1:0] rd_addr, rd_addr_out, wr_addr, host_addr;
    logic          rd_addr_valid, rd_valid, wr_valid, wr_ready;
    logic [RW-1:0] rd_row, wr_row, host_row_in, host_row_out;
    logic          host_we, host_re, host_rd_col, host_rd_valid, host_err, busy;
    logic [15:0]   rd_cnt, wr_cnt;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] model [SIZE];
    logic [RW-1:0] rd_q [$];
    logic [AW-1:0] rda_q [$];
    logic [RW-1:0] host_q [$];

    always #5 clk = ~clk;

    mat_row_server #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .start_i         (start),
        .done_i          (done),
        .rd_addr_i       (rd_addr),
        .rd_addr_valid_i (rd_addr_valid),
        .rd_row_o        (rd_row),
        .rd_addr_o       (rd_addr_out),
        .rd_valid_o      (rd_valid),
        .wr_row_i        (wr_row),
        .wr_addr_i       (wr_addr),
        .wr_valid_i      (wr_valid),
        .wr_ready_o      (wr_ready),
        .host_we_i       (host_we),
        .host_addr_i     (host_addr),
        .host_row_i      (host_row_in),
        .host_re_i       (host_re),
        .host_rd_col_i   (host_rd_col),
        .host_row_o      (host_row_out),
        .host_rd_valid_o (host_rd_valid),
        .host_err_o      (host_err),
        .busy_o          (busy),
        .rd_cnt_o        (rd_cnt),
        .wr_cnt_o        (wr_cnt)
    );

    // Element j of row k: real = k*4 + j + seed, imag = seed*(j+1).
    function automatic logic [RW-1:0] mk_row(int k, int seed);
        logic [RW-1:0] r;
        for (int j = 0; j < SIZE; j++) begin
            r[j*EW +: WIDTH]         = 64'(k * 4 + j + seed);
            r[j*EW + WIDTH +: WIDTH] = 64'(seed * (j + 1));
        end
        return r;
    endfunction

    task automatic idle_inputs();
        flush = 0; start = 0; done = 0;
        rd_addr = '0; rd_addr_valid = 0;
        wr_row = '0; wr_addr = '0; wr_valid = 0;
        host_we = 0; host_addr = '0; host_row_in = '0; host_re = 0; host_rd_col = 0;
    endtask

    task automatic check_rd(string name);
        logic [RW-1:0] er;
        logic [AW-1:0] ea;
        checks++;
        if (rd_q.size() == 0 || rda_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty rd_valid=%0b", name, rd_valid);
        end else begin
            er = rd_q.pop_front();
            ea = rda_q.pop_front();
            if (rd_valid !== 1'b1 || rd_row !== er || rd_addr_out !== ea) begin
                errors++;
                $display("FAIL %s valid=%0b addr=%0d row=%h expected addr=%0d row=%h",
                         name, rd_valid, rd_addr_out, rd_row, ea, er);
            end
        end
    endtask

    task automatic check_host(string name);
        logic [RW-1:0] er;
        checks++;
        if (host_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty host_rd_valid=%0b", name, host_rd_valid);
        end else begin
            er = host_q.pop_front();
            if (host_rd_valid !== 1'b1 || host_err !== 1'b0 || host_row_out !== er) begin
                errors++;
                $display("FAIL %s valid=%0b err=%0b row=%h expected row=%h",
                         name, host_rd_valid, host_err, host_row_out, er);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        checks++;
        if ({rd_valid, host_rd_valid, host_err, busy, wr_ready} !== 5'b0 ||
            rd_cnt !== 16'h0 || wr_cnt !== 16'h0 || rd_addr_out !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b cnt=%h/%h expected 00000 cnt=0/0",
                     {rd_valid, host_rd_valid, host_err, busy, wr_ready}, rd_cnt, wr_cnt);
        end
        checks++;
        if (rd_row !== '0 || host_row_out !== '0) begin
            errors++;
            $display("FAIL reset_data rd_row=%h host_row=%h expected 0", rd_row, host_row_out);
        end
        for (int k = 0; k < SIZE; k++) model[k] = '0;
    endtask

    task automatic test_host_load();
        host_re = 1; host_addr = 2'd0; host_q.push_back(model[0]);
        @(negedge clk);
        check_host("host_read_reset_mem");
        host_re = 0;
        for (int k = 0; k < SIZE; k++) begin
            host_we = 1; host_addr = AW'(k); host_row_in = mk_row(k, 0);
            model[k] = mk_row(k, 0);
            @(negedge clk);
        end
        host_we = 0;
        host_re = 1; host_addr = 2'd2; host_q.push_back(model[2]);
        @(negedge clk);
        check_host("host_read_row2");
        host_re = 0;
        @(negedge clk);
        checks++;
        if (host_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL host_valid_drop got %0b expected 0", host_rd_valid);
        end
        host_we = 1; host_re = 1; host_addr = 2'd1; host_row_in = mk_row(1, 5);
        model[1] = mk_row(1, 5); host_q.push_back(model[1]);
        @(negedge clk);
        check_host("host_we_re_same_addr");
        host_we = 1; host_re = 0; host_row_in = mk_row(1, 0); model[1] = mk_row(1, 0);
        @(negedge clk);
        host_we = 0;
    endtask

    task automatic test_back_to_back();
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b1 || rd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL start busy=%0b wr_ready=%0b rd_cnt=%0d expected 1 1 0", busy, wr_ready, rd_cnt);
        end
        for (int i = 0; i < SIZE; i++) begin
            rd_addr_valid = 1; rd_addr = AW'(i);
            rd_q.push_back(model[i]); rda_q.push_back(AW'(i));
            @(negedge clk);
            check_rd($sformatf("b2b_read_%0d", i));
        end
        rd_addr_valid = 0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_cnt !== 16'd4) begin
            errors++;
            $display("FAIL b2b_cnt rd_valid=%0b rd_cnt=%0d expected 0 4", rd_valid, rd_cnt);
        end
    endtask

    task automatic test_forward();
        wr_valid = 1; wr_addr = 2'd1; wr_row = mk_row(1, 9);
        rd_addr_valid = 1; rd_addr = 2'd1;
        model[1] = mk_row(1, 9);
        rd_q.push_back(model[1]); rda_q.push_back(2'd1);
        @(negedge clk);
        wr_valid = 0; rd_addr_valid = 0;
        check_rd("write_first_fwd");
        checks++;
        if (wr_cnt !== 16'd1 || rd_cnt !== 16'd5) begin
            errors++;
            $display("FAIL fwd_cnt wr_cnt=%0d rd_cnt=%0d expected 1 5", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_host_err();
        host_re = 1; host_addr = 2'd2;
        @(negedge clk);
        host_re = 0;
        host_we = 1; host_addr = 2'd0; host_row_in = mk_row(7, 7);
        checks++;
        if (host_err !== 1'b1 || host_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL host_re_in_engine err=%0b valid=%0b expected 1 0", host_err, host_rd_valid);
        end
        @(negedge clk);
        host_we = 0;
        start = 1;
        checks++;
        if (host_err !== 1'b1) begin
            errors++;
            $display("FAIL host_we_in_engine err=%0b expected 1", host_err);
        end
        @(negedge clk);
        start = 0;
        checks++;
        if (host_err !== 1'b0 || busy !== 1'b1 || rd_cnt !== 16'd5 || wr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL start_in_engine err=%0b busy=%0b cnt=%0d/%0d expected 0 1 5/1",
                     host_err, busy, rd_cnt, wr_cnt);
        end
        done = 1;
        @(negedge clk);
        done = 0;
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL done busy=%0b wr_ready=%0b expected 0 0", busy, wr_ready);
        end
        rd_addr_valid = 1; rd_addr = 2'd0; wr_valid = 1; wr_addr = 2'd0; wr_row = mk_row(8, 8);
        host_re = 1; host_addr = 2'd2; host_q.push_back(model[2]);
        @(negedge clk);
        rd_addr_valid = 0; wr_valid = 0; host_re = 0;
        check_host("host_read_after_done");
        checks++;
        if (rd_valid !== 1'b0 || rd_cnt !== 16'd5 || wr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL idle_engine_ignored rd_valid=%0b cnt=%0d/%0d expected 0 5/1",
                     rd_valid, rd_cnt, wr_cnt);
        end
        host_re = 1; host_addr = 2'd0; host_q.push_back(model[0]);
        @(negedge clk);
        host_re = 0;
        check_host("dropped_writes_row0");
    endtask

    task automatic test_flush();
        start = 1;
        @(negedge clk);
        start = 0;
        rd_addr_valid = 1; rd_addr = 2'd3;
        rd_q.push_back(model[3]); rda_q.push_back(2'd3);
        @(negedge clk);
        check_rd("read_before_flush");
        checks++;
        if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL start_clears_cnt cnt=%0d/%0d expected 1/0", rd_cnt, wr_cnt);
        end
        flush = 1; rd_addr = 2'd0;
        @(negedge clk);
        flush = 0; rd_addr_valid = 0;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush rd_valid=%0b busy=%0b expected 0 0", rd_valid, busy);
        end
        host_re = 1; host_addr = 2'd1; host_q.push_back(model[1]);
        @(negedge clk);
        host_re = 0;
        check_host("flush_mem_retained");
    endtask

    task automatic test_transpose();
        logic [RW-1:0] exp_col;
        for (int k = 0; k < SIZE; k++) begin
            host_we = 1; host_addr = AW'(k); host_row_in = mk_row(k, 0);
            model[k] = mk_row(k, 0);
            @(negedge clk);
        end
        host_we = 0;
`ifdef MAT_ROW_SERVER_TRANSPOSE_EN
        for (int k = 0; k < SIZE; k++) exp_col[k*EW +: EW] = model[k][3*EW +: EW];
`else
        exp_col = model[3];
`endif
        host_re = 1; host_rd_col = 1; host_addr = 2'd3; host_q.push_back(exp_col);
        @(negedge clk);
        host_re = 0; host_rd_col = 0;
        check_host("host_col3_read");
    endtask

    task automatic test_saturate();
        start = 1;
        @(negedge clk);
        start = 0;
        rd_addr_valid = 1; rd_addr = 2'd0;
        wr_valid = 1; wr_addr = 2'd2; wr_row = model[2];
        repeat (65540) @(negedge clk);
        rd_addr_valid = 0; wr_valid = 0;
        checks++;
        if (rd_cnt !== 16'hFFFF || wr_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate cnt=%h/%h expected ffff/ffff", rd_cnt, wr_cnt);
        end
        done = 1;
        @(negedge clk);
        done = 0;
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_back_to_back();
        test_forward();
        test_host_err();
        test_flush();
        test_transpose();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
